i2c_bus_arbiter: RTL

Two-requester arbiter sharing one `i2c_master` command/data interface, so the MPU6050 poller (requester 0) and a second I2C client (requester 1) can use the same Pmod SCL/SDA pair. Each requester sees a port identical to the `i2c_master` handshake, plus a `req`/`gnt` pair. The block sits between the clients and the single `i2c_master` instance. It grants the bus round-robin, holds each grant for a whole multi-transaction session, and can optionally abort a session that hangs.

---
 rtl/i2c_bus_arbiter_if.sv | 30 +++
 rtl/i2c_bus_arbiter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/i2c_bus_arbiter_if.sv
// Handshake bundle of one i2c_master port: command fields, valids, readies, read data and status.
// "master" drives the command side; "slave" answers with readies, data and NACK.
interface i2c_bus_arbiter_if;
    logic [6:0] slave_addr;
    logic [7:0] reg_addr;
    logic [4:0] byte_len;
    logic [7:0] wdata;
    logic       cmd_valid;
    logic       write_valid;
    logic       read_valid;
    logic       rw_mode;
    logic       cmd_ready;
    logic       write_ready;
    logic       read_ready;
    logic [7:0] read_data;
    logic       data_valid;
    logic       nack;

    modport master (
        output slave_addr, reg_addr, byte_len, wdata,
        output cmd_valid, write_valid, read_valid, rw_mode,
        input  cmd_ready, write_ready, read_ready, read_data, data_valid, nack
    );

    modport slave (
        input  slave_addr, reg_addr, byte_len, wdata,
        input  cmd_valid, write_valid, read_valid, rw_mode,
        output cmd_ready, write_ready, read_ready, read_data, data_valid, nack
    );
endinterface

// File: rtl/i2c_bus_arbiter.sv
// Round-robin, session-holding arbiter letting two requesters share one i2c_master.
// Optional session watchdog: define I2C_ARB_TIMEOUT_EN to abort sessions after TIMEOUT_CYCLES.
//
// state  | meaning
// IDLE   | no grant; waits for an eligible request while the master is idle
// GRANT0 | requester 0 owns the master for its whole session
// GRANT1 | requester 1 owns the master for its whole session
// ABORT  | hung session cut off; waits for the master to return idle
module i2c_bus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 2_000_000
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               req0_i,
    input  logic               req1_i,
    output logic               gnt0_o,
    output logic               gnt1_o,
    i2c_bus_arbiter_if.slave   r0,
    i2c_bus_arbiter_if.slave   r1,
    i2c_bus_arbiter_if.master  m,
    output logic               timeout_o
);

    typedef enum logic [1:0] {S_IDLE, S_GRANT0, S_GRANT1, S_ABORT} state_t;

    localparam logic [21:0] TO_LAST = 22'(TIMEOUT_CYCLES - 1);

    state_t state_q, state_d;
    logic   last_q, last_d;
    logic   gnt0_q, gnt0_d;
    logic   gnt1_q, gnt1_d;
    logic   elig0, elig1;
    logic   expired;

`ifdef I2C_ARB_TIMEOUT_EN
    logic [21:0] cnt_q, cnt_d;
    logic [1:0]  blocked_q, blocked_d;
    logic        timeout_q, timeout_d;

    assign elig0     = req0_i & ~blocked_q[0];
    assign elig1     = req1_i & ~blocked_q[1];
    assign expired   = (cnt_q == TO_LAST);
    assign timeout_o = timeout_q;

    always_comb begin
        cnt_d = '0;
        if (state_q == S_GRANT0 || state_q == S_GRANT1) begin
            cnt_d = cnt_q + 22'd1;
        end
        // A flag is raised by the abort and only a dropped request clears it.
        blocked_d[0] = (state_q == S_GRANT0 && state_d == S_ABORT) | (blocked_q[0] & req0_i);
        blocked_d[1] = (state_q == S_GRANT1 && state_d == S_ABORT) | (blocked_q[1] & req1_i);
        timeout_d    = (state_q == S_ABORT) && m.cmd_ready;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q     <= '0;
            blocked_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            blocked_q <= blocked_d;
            timeout_q <= timeout_d;
        end
    end
`else
    logic unused_cfg;

    assign elig0      = req0_i;
    assign elig1      = req1_i;
    assign expired    = 1'b0;
    assign timeout_o  = 1'b0;
    assign unused_cfg = ^TO_LAST;
`endif

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            S_IDLE: begin
                if (m.cmd_ready) begin
                    // On contention the requester that was not granted last wins.
                    if (elig0 && (!elig1 || last_q)) begin
                        state_d = S_GRANT0;
                        last_d  = 1'b0;
                    end else if (elig1) begin
                        state_d = S_GRANT1;
                        last_d  = 1'b1;
                    end
                end
            end
            S_GRANT0: begin
                if (!req0_i && m.cmd_ready) state_d = S_IDLE;
                else if (expired)          state_d = S_ABORT;
            end
            S_GRANT1: begin
                if (!req1_i && m.cmd_ready) state_d = S_IDLE;
                else if (expired)          state_d = S_ABORT;
            end
            default: begin
                if (m.cmd_ready) state_d = S_IDLE;
            end
        endcase
        gnt0_d = (state_d == S_GRANT0);
        gnt1_d = (state_d == S_GRANT1);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            last_q  <= 1'b1;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
        end
    end

    assign gnt0_o = gnt0_q;
    assign gnt1_o = gnt1_q;

    always_comb begin
        m.slave_addr   = '0;
        m.reg_addr     = '0;
        m.byte_len     = '0;
        m.wdata        = '0;
        m.cmd_valid    = 1'b0;
        m.write_valid  = 1'b0;
        m.read_valid   = 1'b0;
        m.rw_mode      = 1'b0;
        r0.cmd_ready   = 1'b0;
        r0.write_ready = 1'b0;
        r0.read_ready  = 1'b0;
        r0.read_data   = '0;
        r0.data_valid  = 1'b0;
        r0.nack        = 1'b0;
        r1.cmd_ready   = 1'b0;
        r1.write_ready = 1'b0;
        r1.read_ready  = 1'b0;
        r1.read_data   = '0;
        r1.data_valid  = 1'b0;
        r1.nack        = 1'b0;
        case (state_q)
            S_GRANT0: begin
                m.slave_addr   = r0.slave_addr;
                m.reg_addr     = r0.reg_addr;
                m.byte_len     = r0.byte_len;
                m.wdata        = r0.wdata;
                m.cmd_valid    = r0.cmd_valid;
                m.write_valid  = r0.write_valid;
                m.read_valid   = r0.read_valid;
                m.rw_mode      = r0.rw_mode;
                r0.cmd_ready   = m.cmd_ready;
                r0.write_ready = m.write_ready;
                r0.read_ready  = m.read_ready;
                r0.read_data   = m.read_data;
                r0.data_valid  = m.data_valid;
                r0.nack        = m.nack;
            end
            S_GRANT1: begin
                m.slave_addr   = r1.slave_addr;
                m.reg_addr     = r1.reg_addr;
                m.byte_len     = r1.byte_len;
                m.wdata        = r1.wdata;
                m.cmd_valid    = r1.cmd_valid;
                m.write_valid  = r1.write_valid;
                m.read_valid   = r1.read_valid;
                m.rw_mode      = r1.rw_mode;
                r1.cmd_ready   = m.cmd_ready;
                r1.write_ready = m.write_ready;
                r1.read_ready  = m.read_ready;
                r1.read_data   = m.read_data;
                r1.data_valid  = m.data_valid;
                r1.nack        = m.nack;
            end
            default: ;
        endcase
    end

endmodule
